tmr_scrub_ctrl: RTL
===================

# tmr_scrub_ctrl

Fault monitor and scrub controller sitting directly downstream of the three replicated 8-bit counters in the TMR counter system. Consumes the three replica values, produces the registered bitwise-majority count, identifies a single persistently divergent replica, and drives a req/ack scrub handshake back to the counter stage so the faulty replica reloads the voted value. Also keeps a saturating error-event count and a sticky uncorrectable flag for status readout.

## Interface
- `WIDTH`, 8, replica and voted data width
- `PERSIST`, 2, consecutive cycles (≥1) a single-replica mismatch must persist before a scrub is requested
- `CNT_W`, 8, width of the error-event counter

- `clk` in 1, single clock, all state updates on rising edge
- `rst` in 1, synchronous, active-low reset
- `q_a`, `q_b`, `q_c` in WIDTH each, replica counter values
- `q_voted` out WIDTH, registered bitwise majority of the replicas
- `mismatch` out 1, registered; any replica differs from the majority
- `fault_id` out 2, registered; 0 none, 1 = a, 2 = b, 3 = c
- `scrub_req` out 1, request for replica `fault_id` to reload
- `scrub_val` out WIDTH, value to load; combinational majority of the current inputs
- `scrub_ack` in 1, counter stage has loaded `scrub_val` this cycle
- `err_count` out CNT_W, saturating count of mismatch events
- `uncorr` out 1, sticky; two or more replicas disagreed with the majority

## Operation
- Majority per bit: `(a&b)|(a&c)|(b&c)`. Per-replica divergence: replica ≠ majority.
- Single divergence: exactly one replica diverges -> candidate id. Multi divergence: two or more diverge (possible with per-bit splits) -> set `uncorr`, no scrub.
- FSM states:
  - IDLE: on single divergence -> SUSPECT, load persistence counter with 1, latch candidate id, increment `err_count`.
  - SUSPECT: same candidate still divergent -> counter +1; on reaching PERSIST -> REQ. Divergence cleared -> IDLE (transient, already counted). Candidate changes -> stay in SUSPECT, restart count at 1 with new id, increment `err_count`. With PERSIST = 1, IDLE goes straight to REQ.
  - REQ: `scrub_req` = 1, `fault_id` held at latched id. Stay until `scrub_ack` = 1 -> HOLD.
  - HOLD: one settle cycle, `scrub_req` = 0, then IDLE.
- Multi divergence in any state: `uncorr` <= 1, FSM -> IDLE, `scrub_req` drops next edge; `err_count` increments once per entry to the multi condition.
- Counter contract: on `scrub_ack` the faulty replica loads `scrub_val` in place of its own next value, applying its own enable increment to it.
- `err_count` saturates at 2^CNT_W − 1, never wraps.

## Timing
- Reset (rst = 0 at an edge): `q_voted` = 0, `mismatch` = 0, `fault_id` = 0, `scrub_req` = 0, `err_count` = 0, `uncorr` = 0, FSM = IDLE. Applies mid-handshake; `scrub_req` falls on that edge.
- `q_voted`, `mismatch`, `fault_id`: 1-cycle latency from inputs.
- Scrub latency: first divergent input cycle at edge N -> `scrub_req` high after edge N+PERSIST.
- `scrub_req` held stable until the edge where `scrub_ack` is sampled high; falls on that edge. `scrub_ack` while not in REQ is ignored.
- `scrub_ack` coinciding with multi divergence: multi wins (`uncorr` set, IDLE).
- `uncorr` cleared only by reset.

## Structure
- Package `tmr_pkg`: `fault_id_t` enum (NONE, A, B, C), `scrub_state_t` enum (IDLE, SUSPECT, REQ, HOLD), default WIDTH constant.
- Sub-module `tmr_majority`: combinational, WIDTH-parameterised; outputs majority vector and 3-bit divergence vector. Instantiated once; the top holds the FSM, counters and output registers.

## Test plan
- Clean count 0->20, all replicas equal -> `q_voted` tracks one cycle later, `mismatch` = 0, `err_count` = 0, no `scrub_req`.
- `q_b` forced to 0xFF for one cycle, PERSIST = 2 -> `mismatch` pulses 1 cycle, `fault_id` = 2 for that cycle, `err_count` = 1, `scrub_req` never asserted.
- `q_c` forced to 0xEF persistently, `scrub_ack` delayed 3 cycles -> `scrub_req` high 2 edges after fault, `fault_id` = 3, held 3 cycles, drops on ack edge, HOLD one cycle, `q_voted` stays correct throughout.
- `q_b` = 0x6F and `q_c` = 0xAF simultaneously against `q_a` = 0x0F -> `uncorr` = 1 and stays 1, no scrub, `err_count` +1.
- 300 single-cycle transients with CNT_W = 8 -> `err_count` stops at 255.
- rst = 0 while `scrub_req` high -> all outputs at reset values after that edge; no ack needed.

Source files
------------

// File: rtl/tmr_pkg.sv
// Shared types and defaults for the TMR counter fault monitor and scrub controller.
package tmr_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        A    = 2'd1,
        B    = 2'd2,
        C    = 2'd3
    } fault_id_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SUSPECT = 2'd1,
        REQ     = 2'd2,
        HOLD    = 2'd3
    } scrub_state_t;

endpackage

// File: rtl/tmr_majority.sv
// Bitwise 2-of-3 voter with per-replica divergence flags (bit 0 = a, 1 = b, 2 = c).
module tmr_majority #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] maj,
    output logic [2:0]       div
);

    assign maj = (a & b) | (a & c) | (b & c);
    assign div = {c != maj, b != maj, a != maj};

endmodule

// File: rtl/tmr_scrub_ctrl.sv
// Votes the three replica counters, tracks a persistently divergent replica and
// runs the req/ack scrub handshake that reloads it with the voted value.
module tmr_scrub_ctrl
    import tmr_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int PERSIST = 2,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] q_a,
    input  logic [WIDTH-1:0] q_b,
    input  logic [WIDTH-1:0] q_c,
    output logic [WIDTH-1:0] q_voted,
    output logic             mismatch,
    output logic [1:0]       fault_id,
    output logic             scrub_req,
    output logic [WIDTH-1:0] scrub_val,
    input  logic             scrub_ack,
    output logic [CNT_W-1:0] err_count,
    output logic             uncorr
);

    localparam int PW = $clog2(PERSIST + 1);

    logic [WIDTH-1:0] maj;
    logic [2:0]       div;
    logic             single;
    logic             multi;
    fault_id_t        cand;

    scrub_state_t     state;
    scrub_state_t     state_next;
    logic [PW-1:0]    pcnt;
    logic [PW-1:0]    pcnt_next;
    fault_id_t        id_lat;
    fault_id_t        id_next;
    logic             err_inc;
    logic             multi_p1;

    tmr_majority #(.WIDTH(WIDTH)) u_majority (
        .a   (q_a),
        .b   (q_b),
        .c   (q_c),
        .maj (maj),
        .div (div)
    );

    always_comb begin
        single = 1'b0;
        multi  = 1'b0;
        cand   = NONE;
        case (div)
            3'b000: ;
            3'b001: begin single = 1'b1; cand = A; end
            3'b010: begin single = 1'b1; cand = B; end
            3'b100: begin single = 1'b1; cand = C; end
            default: multi = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Multi divergence overrides every state, including a pending ack in REQ.
    always_comb begin
        state_next = state;
        pcnt_next  = pcnt;
        id_next    = id_lat;
        err_inc    = 1'b0;
        if (multi) begin
            state_next = IDLE;
            pcnt_next  = '0;
            id_next    = NONE;
            err_inc    = !multi_p1;
        end else begin
            case (state)
                IDLE: begin
                    if (single) begin
                        state_next = (PERSIST <= 1) ? REQ : SUSPECT;
                        pcnt_next  = PW'(1);
                        id_next    = cand;
                        err_inc    = 1'b1;
                    end
                end
                SUSPECT: begin
                    if (!single) begin
                        state_next = IDLE;
                        pcnt_next  = '0;
                    end else if (cand != id_lat) begin
                        pcnt_next = PW'(1);
                        id_next   = cand;
                        err_inc   = 1'b1;
                    end else begin
                        pcnt_next = pcnt + PW'(1);
                        if (int'(pcnt) + 1 >= PERSIST) begin
                            state_next = REQ;
                        end
                    end
                end
                REQ: begin
                    if (scrub_ack) begin
                        state_next = HOLD;
                    end
                end
                HOLD: begin
                    state_next = IDLE;
                    pcnt_next  = '0;
                    id_next    = NONE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        scrub_req = (state == REQ);
        scrub_val = maj;
    end

    // While a request is outstanding fault_id reports the latched replica, otherwise the live one.
    always_ff @(posedge clk) begin
        if (!rst) begin
            q_voted   <= '0;
            mismatch  <= 1'b0;
            fault_id  <= NONE;
            err_count <= '0;
            uncorr    <= 1'b0;
            pcnt      <= '0;
            id_lat    <= NONE;
            multi_p1  <= 1'b0;
        end else begin
            q_voted  <= maj;
            mismatch <= |div;
            fault_id <= (state_next == REQ) ? id_next : cand;
            pcnt     <= pcnt_next;
            id_lat   <= id_next;
            multi_p1 <= multi;
            if (multi) begin
                uncorr <= 1'b1;
            end
            if (err_inc && (err_count != '1)) begin
                err_count <= err_count + CNT_W'(1);
            end
        end
    end

endmodule
